// File: rtl/photon_loop_scheduler.sv
// rtl/photon_loop_scheduler.sv - head-of-pipeline recirculate/refill scheduler for the photon loop
module photon_loop_scheduler #(
    parameter int PIPE_DEPTH = 50,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_photons,
    input  logic             i_stall,
    input  logic             i_src_valid,
    output logic             o_src_ready,
    input  logic             i_ret_dead,
    output logic             o_pipe_enable,
    output logic             o_inject,
    output logic [CNT_W-1:0] o_launched,
    output logic [CNT_W-1:0] o_retired,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      launched;
    logic [CNT_W-1:0]      retired;
    logic [CNT_W-1:0]      launched_next;
    logic [PIPE_DEPTH-1:0] occ;
    logic                  err;

    logic st_run;
    logic st_drain;
    logic pipe_enable;
    logic inject;
    logic head_occ;
    logic retire_evt;
    logic err_evt;
    logic start_acc;

    assign st_run      = (state == S_RUN);
    assign st_drain    = (state == S_DRAIN);
    assign pipe_enable = (st_run | st_drain) & ~i_stall;
    assign head_occ    = occ[PIPE_DEPTH-1];

    // A live photon at the head always recirculates; only a dead or empty slot is refilled.
    assign inject = st_run & pipe_enable & i_ret_dead & i_src_valid
                  & (launched < count) & ~i_abort;

    assign retire_evt    = pipe_enable & head_occ & i_ret_dead;
    assign err_evt       = pipe_enable & ~head_occ & ~i_ret_dead;
    assign start_acc     = (state == S_IDLE) & i_start;
    assign launched_next = launched + {{(CNT_W-1){1'b0}}, inject};

    assign o_pipe_enable = pipe_enable;
    assign o_inject      = inject;
    assign o_src_ready   = inject;
    assign o_launched    = launched;
    assign o_retired     = retired;
    assign o_busy        = st_run | st_drain;
    assign o_done        = (state == S_DONE);
    assign o_err         = err;

    // Run sequencing and launched/retired bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count    <= '0;
            launched <= '0;
            retired  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        count    <= i_num_photons;
                        launched <= '0;
                        retired  <= '0;
                        state    <= (i_num_photons == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    launched <= launched_next;
                    if (retire_evt)
                        retired <= retired + 1'b1;
                    // Leave RUN on the same edge that launches the final photon.
                    if (i_abort || (launched_next == count))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (retire_evt)
                        retired <= retired + 1'b1;
                    if (retired == launched)
                        state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Occupancy shadow of the photon pipeline; moves in lockstep with the stage enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ <= '0;
        end else if (pipe_enable) begin
            occ <= {occ[PIPE_DEPTH-2:0], inject | (head_occ & ~i_ret_dead)};
        end
    end

    // Sticky flag for a live photon appearing in a slot the shadow believes is free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (start_acc) begin
            err <= 1'b0;
        end else if (err_evt) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_photon_loop_scheduler.sv
// tb/tb_photon_loop_scheduler.sv - directed self-checking bench for photon_loop_scheduler
module tb_photon_loop_scheduler;

    localparam int PIPE_DEPTH = 4;
    localparam int CNT_W      = 32;

    logic             clock;
    logic             reset;
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_num_photons;
    logic             i_stall;
    logic             i_src_valid;
    logic             o_src_ready;
    logic             i_ret_dead;
    logic             o_pipe_enable;
    logic             o_inject;
    logic [CNT_W-1:0] o_launched;
    logic [CNT_W-1:0] o_retired;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    int checks;
    int failures;

    photon_loop_scheduler #(
        .PIPE_DEPTH(PIPE_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_num_photons(i_num_photons),
        .i_stall      (i_stall),
        .i_src_valid  (i_src_valid),
        .o_src_ready  (o_src_ready),
        .i_ret_dead   (i_ret_dead),
        .o_pipe_enable(o_pipe_enable),
        .o_inject     (o_inject),
        .o_launched   (o_launched),
        .o_retired    (o_retired),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input int n);
        i_num_photons = n;
        i_start       = 1'b1;
        tick();
        i_start       = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_num_photons = '0;
        i_stall       = 1'b0;
        i_src_valid   = 1'b0;
        i_ret_dead    = 1'b0;

        // Test 1: reset held with toggling inputs, then a zero-photon run
        for (int i = 0; i < 4; i++) begin
            i_start       = i[0];
            i_abort       = ~i[0];
            i_stall       = i[1];
            i_src_valid   = 1'b1;
            i_ret_dead    = i[0];
            i_num_photons = i + 7;
            @(negedge clock);
            chk("rst_flags", {26'd0, o_pipe_enable, o_inject, o_src_ready, o_busy, o_done, o_err}, 32'd0);
            chk("rst_counts", o_launched | o_retired, 32'd0);
        end
        i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0;
        i_src_valid = 1'b0; i_ret_dead = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        start_run(0);
        chk("t1_done", o_done, 1);
        chk("t1_busy", o_busy, 0);
        chk("t1_launched", o_launched, 0);
        tick();
        chk("t1_done_off", o_done, 0);

        // Test 2: three photons, each returns dead on its first lap
        i_src_valid = 1'b1;
        i_ret_dead  = 1'b1;
        start_run(3);
        for (int c = 1; c <= 10; c++) begin
            chk("t2_inject", o_inject, c <= 3);
            chk("t2_ready", o_src_ready, c <= 3);
            chk("t2_busy", o_busy, c <= 8);
            chk("t2_done", o_done, c == 9);
            chk("t2_retired", o_retired, (c <= 5) ? 0 : ((c - 5 > 3) ? 3 : c - 5));
            tick();
        end
        chk("t2_launched", o_launched, 3);

        // Test 3: eight photons, each survives one lap and dies on the second
        start_run(8);
        for (int c = 1; c <= 23; c++) begin
            i_ret_dead = (c >= 17) ? 1'b1 : ((((c - 1) / 4) % 2) == 0);
            #1;
            chk("t3_inject", o_inject, (c <= 4) || (c >= 9 && c <= 12));
            chk("t3_done", o_done, c == 22);
            tick();
        end
        chk("t3_launched", o_launched, 8);
        chk("t3_retired", o_retired, 8);
        chk("t3_err", o_err, 0);

        // Test 4: test 2 with a five-cycle stall after the first injection
        i_ret_dead = 1'b1;
        start_run(3);
        for (int c = 1; c <= 15; c++) begin
            i_stall = (c >= 2 && c <= 6);
            #1;
            chk("t4_enable", o_pipe_enable, (c <= 13) && !(c >= 2 && c <= 6));
            chk("t4_busy", o_busy, c <= 13);
            chk("t4_inject", o_inject, (c == 1) || (c == 7) || (c == 8));
            chk("t4_done", o_done, c == 14);
            if (c == 4)
                chk("t4_frozen", o_launched, 1);
            tick();
        end
        i_stall = 1'b0;
        chk("t4_retired", o_retired, 3);

        // Test 5: abort after two injections; start during DRAIN is ignored
        start_run(10);
        for (int c = 1; c <= 9; c++) begin
            i_abort = (c == 3);
            i_start = (c == 4) || (c == 5);
            #1;
            chk("t5_inject", o_inject, c <= 2);
            chk("t5_busy", o_busy, c <= 7);
            chk("t5_done", o_done, c == 8);
            if (c == 5)
                chk("t5_launched", o_launched, 2);
            tick();
        end
        i_abort = 1'b0;
        i_start = 1'b0;
        chk("t5_retired", o_retired, 2);

        // Test 6: live photon in a free slot, then asynchronous reset during DRAIN
        i_src_valid = 1'b0;
        i_ret_dead  = 1'b0;
        start_run(5);
        chk("t6_err_clear", o_err, 0);
        tick();
        chk("t6_err_set", o_err, 1);
        i_ret_dead = 1'b1;
        tick();
        chk("t6_err_sticky", o_err, 1);
        i_src_valid = 1'b1;
        tick();
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("t6_drain_busy", o_busy, 1);
        chk("t6_launched", o_launched, 2);
        chk("t6_err_hold", o_err, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_launched", o_launched, 0);
        chk("t6_rst_retired", o_retired, 0);
        chk("t6_rst_err", o_err, 0);
        chk("t6_rst_enable", o_pipe_enable, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("t6_idle", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
